// File: rtl/even_parity_frame_rx_pkg.sv
// Shared types and line constants for the even-parity frame receiver.
// The default data width is chosen so that this receiver matches the downstream 2-bit checker.
package even_parity_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int DEFAULT_DATA_W = 2;

    // The counter needs to be at least 1 bit wide, so that DATA_W=1 still gets a counter.
    function automatic int cnt_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/even_parity_frame_rx_if.sv
// Serial input and buffered frame output bundle of the receiver.
// The slave modport is the receiver; the master modport is the surrounding logic.
interface even_parity_frame_rx_if #(
    parameter int DATA_W = even_parity_frame_rx_pkg::DEFAULT_DATA_W
);

    logic              rx_bit;
    logic              rx_bit_en;
    logic [DATA_W-1:0] data_out;
    logic              par_out;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;
    logic              overrun;

    modport slave (
        input  rx_bit,
        input  rx_bit_en,
        input  out_ready,
        output data_out,
        output par_out,
        output out_valid,
        output frame_err,
        output overrun
    );

    modport master (
        output rx_bit,
        output rx_bit_en,
        output out_ready,
        input  data_out,
        input  par_out,
        input  out_valid,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/even_parity_frame_buf.sv
// Single-entry valid/ready output register. A completed frame loads when the slot is free.
// Otherwise the frame is dropped and a one-cycle overrun pulse is raised.
module even_parity_frame_buf #(
    parameter int DATA_W = even_parity_frame_rx_pkg::DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              par_in,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              par,
    output logic              valid,
    output logic              overrun
);

    logic [DATA_W-1:0] data_reg;
    logic              par_reg;
    logic              valid_reg;
    logic              overrun_reg;
    logic              free;

    // The slot can be refilled on the same cycle the downstream takes the current frame.
    assign free = !valid_reg || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg    <= '0;
            par_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= load && !free;
            if (load && free) begin
                data_reg  <= data_in;
                par_reg   <= par_in;
                valid_reg <= 1'b1;
            end else if (ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign data    = data_reg;
    assign par     = par_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/even_parity_frame_rx.sv
// Start/data/parity/stop deserialiser that feeds the even-parity checker stage.
// It captures the data bits and the parity bit only; the checker downstream evaluates parity.
module even_parity_frame_rx
    import even_parity_frame_rx_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    even_parity_frame_rx_if.slave bus
);

    localparam int                CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    rx_state_t         state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              par_reg;
    logic              frame_err_reg;
    logic              stop_strobe;
    logic              frame_good;
    logic              frame_bad;

    // Shift right, inserting at the MSB, so the first data bit ends up at bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_shift
            if (gi == DATA_W - 1) begin : g_top
                assign shift_next[gi] = bus.rx_bit;
            end else begin : g_low
                assign shift_next[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    assign stop_strobe = bus.rx_bit_en && (state_reg == STOP);
    assign frame_good  = stop_strobe && (bus.rx_bit == STOP_BIT);
    assign frame_bad   = stop_strobe && (bus.rx_bit != STOP_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            par_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= frame_bad;
            if (bus.rx_bit_en) begin
                case (state_reg)
                    IDLE: begin
                        if (bus.rx_bit == START_BIT) begin
                            state_reg <= DATA;
                            cnt_reg   <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= shift_next;
                        if (cnt_reg == LAST_CNT) begin
                            state_reg <= PARITY;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    PARITY: begin
                        par_reg   <= bus.rx_bit;
                        state_reg <= STOP;
                    end
                    STOP: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.frame_err = frame_err_reg;

    // A bad stop bit never reaches the buffer, so frame_err and overrun cannot coincide.
    even_parity_frame_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (frame_good),
        .data_in (shift_reg),
        .par_in  (par_reg),
        .ready   (bus.out_ready),
        .data    (bus.data_out),
        .par     (bus.par_out),
        .valid   (bus.out_valid),
        .overrun (bus.overrun)
    );

endmodule

// File: tb/tb_even_parity_frame_rx.sv
// Directed scoreboard bench for even_parity_frame_rx. The stimulus queues the expected frames,
// and a negedge monitor pops and compares one frame on each handshake transfer.
module tb_even_parity_frame_rx;
    import even_parity_frame_rx_pkg::*;

    localparam int DATA_W = DEFAULT_DATA_W;

    logic clk = 1'b0;
    logic rst;

    even_parity_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    even_parity_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int ferr_seen = 0;
    int ferr_exp  = 0;
    int ovr_seen  = 0;
    int ovr_exp   = 0;
    int pushed    = 0;
    int xfers     = 0;

    logic [DATA_W:0] exp_q[$];

    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic              prev_rst   = 1'b1;
    logic              prev_ferr  = 1'b0;
    logic              prev_ovr   = 1'b0;
    logic [DATA_W:0]   prev_word  = '0;
    logic [DATA_W:0]   popped;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.rx_bit    = b;
        bus.rx_bit_en = 1'b1;
        tick();
        bus.rx_bit_en = 1'b0;
        bus.rx_bit    = 1'($urandom);
        tick();
        bus.rx_bit    = 1'($urandom);
        tick();
    endtask

    // One frame; the stop-bit outcome is checked one clock after the stop strobe.
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par, input logic stop,
                              input bit ready_on_stop, input bit load, input bit exp_valid,
                              input bit exp_err, input bit exp_ovr,
                              input logic [DATA_W-1:0] exp_data);
        if (load) begin
            exp_q.push_back({par, data});
            pushed++;
        end
        if (exp_err) ferr_exp++;
        if (exp_ovr) ovr_exp++;
        send_bit(START_BIT);
        for (int i = 0; i < DATA_W; i++) send_bit(data[i]);
        send_bit(par);
        bus.rx_bit    = stop;
        bus.rx_bit_en = 1'b1;
        if (ready_on_stop) bus.out_ready = 1'b1;
        tick();
        bus.rx_bit_en = 1'b0;
        bus.rx_bit    = IDLE_LEVEL;
        @(negedge clk);
        check("stop_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("stop_frame_err", 32'(bus.frame_err), 32'(exp_err));
        check("stop_overrun", 32'(bus.overrun), 32'(exp_ovr));
        if (exp_valid) check("stop_data", 32'(bus.data_out), 32'(exp_data));
        tick();
        tick();
    endtask

    // Monitor: scoreboard pops, hold stability while stalled, and pulse width/exclusivity.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.frame_err) begin
                ferr_seen++;
                check("frame_err_width", 32'(prev_ferr), 32'd0);
                check("err_ovr_exclusive", 32'(bus.overrun), 32'd0);
            end
            if (bus.overrun) begin
                ovr_seen++;
                check("overrun_width", 32'(prev_ovr), 32'd0);
            end
            if (prev_valid && !prev_ready && !prev_rst) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_word", 32'({bus.par_out, bus.data_out}), 32'(prev_word));
            end
            if (bus.out_valid && bus.out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got %0h expected none",
                             {bus.par_out, bus.data_out});
                end else begin
                    popped = exp_q.pop_front();
                    xfers++;
                    check("frame_word", 32'({bus.par_out, bus.data_out}), 32'(popped));
                end
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_rst   = rst;
            prev_ferr  = bus.frame_err;
            prev_ovr   = bus.overrun;
            prev_word  = {bus.par_out, bus.data_out};
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.rx_bit    = IDLE_LEVEL;
        bus.rx_bit_en = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_par", 32'(bus.par_out), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic frame: data bits 1,0 -> 2'b01, parity 1.
        bus.out_ready = 1'b1;
        send_frame(2'b01, 1'b1, 1'b1, 0, 1, 1, 0, 0, 2'b01);
        $display("frame data=01 par=1 stop=1 ready=1 done");

        // Bad stop bit, then a good frame.
        send_frame(2'b01, 1'b1, 1'b0, 0, 0, 0, 1, 0, 2'b00);
        @(negedge clk);
        check("frame_err_cleared", 32'(bus.frame_err), 32'd0);
        $display("frame data=01 par=1 stop=0 done");
        send_frame(2'b10, 1'b1, 1'b1, 0, 1, 1, 0, 0, 2'b10);
        $display("frame data=10 par=1 stop=1 after error done");

        // Stalled buffer: the second frame is an overrun; the first one is delivered.
        tick();
        bus.out_ready = 1'b0;
        send_frame(2'b11, 1'b0, 1'b1, 0, 1, 1, 0, 0, 2'b11);
        send_frame(2'b10, 1'b1, 1'b1, 0, 0, 1, 0, 1, 2'b11);
        bus.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("drained_valid", 32'(bus.out_valid), 32'd0);
        $display("overrun sequence data=11 held, data=10 dropped done");

        // Full buffer freed on the same cycle as the next stop strobe.
        tick();
        bus.out_ready = 1'b0;
        send_frame(2'b01, 1'b1, 1'b1, 0, 1, 1, 0, 0, 2'b01);
        send_frame(2'b11, 1'b0, 1'b1, 1, 1, 1, 0, 0, 2'b11);
        $display("same-cycle consume/load data=01 then data=11 done");

        // Reset after one data bit.
        send_bit(START_BIT);
        send_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data", 32'(bus.data_out), 32'd0);
        check("midrst_par", 32'(bus.par_out), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        check("midrst_overrun", 32'(bus.overrun), 32'd0);
        tick();
        send_frame(2'b11, 1'b1, 1'b1, 0, 1, 1, 0, 0, 2'b11);
        $display("mid-frame reset then data=11 par=1 done");

        // Idle line with strobes, then toggling without strobes.
        bus.rx_bit    = IDLE_LEVEL;
        bus.rx_bit_en = 1'b1;
        repeat (8) begin
            tick();
            @(negedge clk);
            check("idle_strobe_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.rx_bit_en = 1'b0;
        repeat (8) begin
            bus.rx_bit = ~bus.rx_bit;
            tick();
            @(negedge clk);
            check("idle_noen_valid", 32'(bus.out_valid), 32'd0);
        end
        tick();
        bus.rx_bit = IDLE_LEVEL;
        send_frame(2'b10, 1'b1, 1'b1, 0, 1, 1, 0, 0, 2'b10);
        $display("idle line then data=10 par=1 done");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("transfer_count", 32'(xfers), 32'(pushed));
        check("frame_err_count", 32'(ferr_seen), 32'(ferr_exp));
        check("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
